// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: commits per-player predictor boxes only at frame ends,
// and runs the idle/countdown/play/over phases with frame-counted timers.
module game_flow_ctrl #(
  parameter int COORD_W        = 11,
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int ROUND_SEC      = 30,
  parameter int STALE_FRAMES   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    start,
  input  logic                    enter_game,
  input  logic                    predict_valid,
  input  logic                    ThisFrameEnd,
  input  logic [1:0][COORD_W-1:0] left_in,
  input  logic [1:0][COORD_W-1:0] right_in,
  input  logic [1:0][COORD_W-1:0] up_in,
  input  logic [1:0][COORD_W-1:0] down_in,
  output logic [1:0][COORD_W-1:0] left,
  output logic [1:0][COORD_W-1:0] right,
  output logic [1:0][COORD_W-1:0] up,
  output logic [1:0][COORD_W-1:0] down,
  output logic [1:0]              box_valid,
  output logic [1:0]              phase,
  output logic [3:0]              countdown,
  output logic [6:0]              time_left,
  output logic                    frame_tick,
  output logic                    game_over
);

  localparam int            FW         = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [7:0]    STALE_MAX  = 8'(STALE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAY      = 2'd2,
    S_OVER      = 2'd3
  } state_t;

  // ---------------- box capture / commit / staleness ----------------
  logic [1:0][COORD_W-1:0] shadow_left_reg, shadow_right_reg, shadow_up_reg, shadow_down_reg;
  logic [1:0][COORD_W-1:0] left_reg, right_reg, up_reg, down_reg;
  logic [1:0][COORD_W-1:0] src_left, src_right, src_up, src_down;
  logic [1:0]              box_valid_reg;
  logic [1:0]              box_ok;
  logic                    pending_reg;
  logic                    commit;
  logic [7:0]              stale_reg;
  logic [7:0]              stale_inc;

  // A same-cycle prediction bypasses the shadow so the freshest box wins.
  assign commit    = ThisFrameEnd & (pending_reg | predict_valid);
  assign src_left  = predict_valid ? left_in  : shadow_left_reg;
  assign src_right = predict_valid ? right_in : shadow_right_reg;
  assign src_up    = predict_valid ? up_in    : shadow_up_reg;
  assign src_down  = predict_valid ? down_in  : shadow_down_reg;
  assign stale_inc = (stale_reg == STALE_MAX) ? stale_reg : stale_reg + 8'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      assign box_ok[gi] = (src_left[gi] < src_right[gi]) && (src_up[gi] < src_down[gi]);
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_left_reg  <= '0;
      shadow_right_reg <= '0;
      shadow_up_reg    <= '0;
      shadow_down_reg  <= '0;
      left_reg         <= '0;
      right_reg        <= '0;
      up_reg           <= '0;
      down_reg         <= '0;
      box_valid_reg    <= '0;
      pending_reg      <= 1'b0;
      stale_reg        <= '0;
    end else begin
      if (predict_valid) begin
        shadow_left_reg  <= left_in;
        shadow_right_reg <= right_in;
        shadow_up_reg    <= up_in;
        shadow_down_reg  <= down_in;
      end
      pending_reg <= ~ThisFrameEnd & (pending_reg | predict_valid);
      if (commit) begin
        left_reg      <= src_left;
        right_reg     <= src_right;
        up_reg        <= src_up;
        down_reg      <= src_down;
        box_valid_reg <= box_ok;
        stale_reg     <= '0;
      end else if (ThisFrameEnd) begin
        stale_reg <= stale_inc;
        if (stale_inc == STALE_MAX) begin
          box_valid_reg <= 2'b00;
        end
      end
    end
  end

  // ---------------- phase FSM and timers ----------------
  state_t        state_reg, state_next;
  logic [3:0]    countdown_reg, countdown_next;
  logic [6:0]    time_left_reg, time_left_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          start_q_reg;
  logic          frame_tick_reg;
  logic          start_edge;
  logic          timed_phase;
  logic          sec_event;

  assign start_edge  = start & ~start_q_reg;
  assign timed_phase = (state_reg == S_COUNTDOWN) || (state_reg == S_PLAY);
  assign sec_event   = timed_phase && ThisFrameEnd && (frame_cnt_reg == FRAME_LAST);

  always_comb begin
    state_next     = state_reg;
    countdown_next = countdown_reg;
    time_left_next = time_left_reg;
    frame_cnt_next = frame_cnt_reg;
    if (timed_phase && ThisFrameEnd) begin
      frame_cnt_next = sec_event ? '0 : frame_cnt_reg + 1'b1;
    end
    if (!enter_game) begin
      state_next     = S_IDLE;
      countdown_next = '0;
      time_left_next = '0;
      frame_cnt_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_edge) begin
            state_next     = S_COUNTDOWN;
            countdown_next = 4'(COUNTDOWN_SEC);
          end
        end
        S_COUNTDOWN: begin
          if (sec_event) begin
            if (countdown_reg == 4'd1) begin
              state_next     = S_PLAY;
              countdown_next = '0;
              time_left_next = 7'(ROUND_SEC);
            end else begin
              countdown_next = countdown_reg - 4'd1;
            end
          end
        end
        S_PLAY: begin
          if (sec_event) begin
            if (time_left_reg == 7'd1) begin
              state_next     = S_OVER;
              time_left_next = '0;
            end else begin
              time_left_next = time_left_reg - 7'd1;
            end
          end
        end
        S_OVER: begin
          if (start_edge) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    // Every phase starts counting its first second from frame zero.
    if (state_next != state_reg) begin
      frame_cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= S_IDLE;
      countdown_reg  <= '0;
      time_left_reg  <= '0;
      frame_cnt_reg  <= '0;
      start_q_reg    <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      countdown_reg  <= countdown_next;
      time_left_reg  <= time_left_next;
      frame_cnt_reg  <= frame_cnt_next;
      start_q_reg    <= start;
      frame_tick_reg <= (state_reg == S_PLAY) && ThisFrameEnd && enter_game;
    end
  end

  assign left       = left_reg;
  assign right      = right_reg;
  assign up         = up_reg;
  assign down       = down_reg;
  assign box_valid  = box_valid_reg;
  assign phase      = state_reg;
  assign countdown  = countdown_reg;
  assign time_left  = time_left_reg;
  assign frame_tick = frame_tick_reg;
  assign game_over  = (state_reg == S_OVER);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a random run checked
// against an elapsed-frame model of the game and a simple box model.
module tb_game_flow_ctrl;
  localparam int CW    = 11;
  localparam int FPS   = 2;
  localparam int CDS   = 3;
  localparam int RS    = 2;
  localparam int STALE = 8;

  logic i_clk = 1'b0;
  logic i_rst_n, start, enter_game, predict_valid, ThisFrameEnd;
  logic [1:0][CW-1:0] left_in, right_in, up_in, down_in;
  logic [1:0][CW-1:0] left, right, up, down;
  logic [1:0] box_valid, phase;
  logic [3:0] countdown;
  logic [6:0] time_left;
  logic frame_tick, game_over;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  game_flow_ctrl #(
    .COORD_W(CW), .FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CDS),
    .ROUND_SEC(RS), .STALE_FRAMES(STALE)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start), .enter_game(enter_game),
    .predict_valid(predict_valid), .ThisFrameEnd(ThisFrameEnd),
    .left_in(left_in), .right_in(right_in), .up_in(up_in), .down_in(down_in),
    .left(left), .right(right), .up(up), .down(down), .box_valid(box_valid),
    .phase(phase), .countdown(countdown), .time_left(time_left),
    .frame_tick(frame_tick), .game_over(game_over)
  );

  // Reference model: boxes tracked directly, game tracked as frames elapsed since start.
  logic [1:0][CW-1:0] m_l, m_r, m_u, m_d, m_sl, m_sr, m_su, m_sd;
  logic [1:0] m_bv;
  bit m_pending, m_tick, m_start_prev, m_active;
  int m_since, m_frames;

  task automatic model_reset();
    m_l = '0; m_r = '0; m_u = '0; m_d = '0;
    m_sl = '0; m_sr = '0; m_su = '0; m_sd = '0;
    m_bv = '0; m_pending = 0; m_tick = 0; m_start_prev = 0;
    m_active = 0; m_since = 0; m_frames = 0;
  endtask

  function automatic int m_phase();
    if (!m_active) return 0;
    if (m_frames < CDS * FPS) return 1;
    if (m_frames < (CDS + RS) * FPS) return 2;
    return 3;
  endfunction

  function automatic int m_countdown();
    return (m_phase() == 1) ? CDS - m_frames / FPS : 0;
  endfunction

  function automatic int m_time_left();
    return (m_phase() == 2) ? RS - (m_frames - CDS * FPS) / FPS : 0;
  endfunction

  task automatic model_step();
    bit cm, st_edge;
    int ph;
    cm = ThisFrameEnd && (m_pending || predict_valid);
    if (cm) begin
      if (predict_valid) begin
        m_l = left_in; m_r = right_in; m_u = up_in; m_d = down_in;
      end else begin
        m_l = m_sl; m_r = m_sr; m_u = m_su; m_d = m_sd;
      end
      for (int p = 0; p < 2; p++) m_bv[p] = (m_l[p] < m_r[p]) && (m_u[p] < m_d[p]);
      m_since = 0;
    end else if (ThisFrameEnd) begin
      if (m_since < STALE) m_since++;
      if (m_since >= STALE) m_bv = 2'b00;
    end
    if (predict_valid) begin
      m_sl = left_in; m_sr = right_in; m_su = up_in; m_sd = down_in;
    end
    m_pending = !ThisFrameEnd && (m_pending || predict_valid);
    ph = m_phase();
    m_tick = (ph == 2) && ThisFrameEnd && enter_game;
    st_edge = start && !m_start_prev;
    m_start_prev = start;
    if (!enter_game) begin
      m_active = 0; m_frames = 0;
    end else if (!m_active) begin
      if (st_edge) begin m_active = 1; m_frames = 0; end
    end else if (ph == 3) begin
      if (st_edge) m_active = 0;
    end else if (ThisFrameEnd) begin
      m_frames++;
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic set_box0(input int l, input int r, input int u, input int d);
    left_in[0] = CW'(l); right_in[0] = CW'(r); up_in[0] = CW'(u); down_in[0] = CW'(d);
    left_in[1] = '0; right_in[1] = '0; up_in[1] = '0; down_in[1] = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 0; start = 0; enter_game = 0; predict_valid = 0; ThisFrameEnd = 0;
    set_box0(0, 0, 0, 0);
    model_reset();
    #2;
    total++;
    if ({left, right, up, down, box_valid, phase, countdown, time_left, frame_tick, game_over} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h required=0",
        {left, right, up, down, box_valid, phase, countdown, time_left, frame_tick, game_over});
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    cycle();
  endtask

  task automatic test_frame_commit();
    set_box0(100, 200, 50, 150);
    predict_valid = 1; cycle(); predict_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      total++;
      if (left[0] !== 11'd0) begin bad++; $display("FAIL commit_hold cyc=%0d got=%0d required=0", i, left[0]); end
    end
    ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0;
    total++;
    if ({left[0], right[0], up[0], down[0]} !== {11'd100, 11'd200, 11'd50, 11'd150}) begin
      bad++; $display("FAIL commit_box got=%0d/%0d/%0d/%0d required=100/200/50/150", left[0], right[0], up[0], down[0]);
    end
    total++;
    if (box_valid !== 2'b01) begin bad++; $display("FAIL commit_valid got=%b required=01", box_valid); end
  endtask

  task automatic test_simultaneous_stale();
    set_box0(100, 100, 100, 100);
    predict_valid = 1; cycle(); predict_valid = 0; cycle();
    ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0;
    total++;
    if (left[0] !== 11'd100 || box_valid !== 2'b00) begin
      bad++; $display("FAIL degenerate_box left=%0d valid=%b required=100/00", left[0], box_valid);
    end
    predict_valid = 1; cycle();
    set_box0(300, 400, 50, 150);
    ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0; predict_valid = 0;
    total++;
    if (left[0] !== 11'd300 || right[0] !== 11'd400 || box_valid !== 2'b01) begin
      bad++; $display("FAIL simultaneous left=%0d right=%0d valid=%b required=300/400/01", left[0], right[0], box_valid);
    end
    for (int i = 1; i <= STALE; i++) begin
      ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0; cycle();
      total++;
      if (box_valid !== ((i < STALE) ? 2'b01 : 2'b00) || left[0] !== 11'd300 || down[0] !== 11'd150) begin
        bad++; $display("FAIL stale frame=%0d valid=%b left=%0d down=%0d", i, box_valid, left[0], down[0]);
      end
    end
    predict_valid = 1; ThisFrameEnd = 1; cycle(); predict_valid = 0; ThisFrameEnd = 0;
    total++;
    if (box_valid !== 2'b01) begin bad++; $display("FAIL stale_restore got=%b required=01", box_valid); end
  endtask

  task automatic test_full_sequence();
    int ticks, ep, ec, et;
    enter_game = 1; start = 0; cycle();
    start = 1; cycle();
    total++;
    if (phase !== 2'd1 || countdown !== 4'd3) begin
      bad++; $display("FAIL seq_start phase=%0d countdown=%0d required=1/3", phase, countdown);
    end
    ticks = 0;
    for (int n = 1; n <= (CDS + RS) * FPS; n++) begin
      ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0;
      if (frame_tick === 1'b1) ticks++;
      if (n < CDS * FPS) begin ep = 1; ec = CDS - n / FPS; et = 0; end
      else if (n < (CDS + RS) * FPS) begin ep = 2; ec = 0; et = RS - (n - CDS * FPS) / FPS; end
      else begin ep = 3; ec = 0; et = 0; end
      total++;
      if (phase !== 2'(ep) || countdown !== 4'(ec) || time_left !== 7'(et)) begin
        bad++; $display("FAIL seq_frame=%0d got=%0d/%0d/%0d required=%0d/%0d/%0d",
          n, phase, countdown, time_left, ep, ec, et);
      end
      cycle();
      if (frame_tick === 1'b1) ticks++;
    end
    ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0;
    if (frame_tick === 1'b1) ticks++;
    repeat (3) begin cycle(); if (frame_tick === 1'b1) ticks++; end
    total++;
    if (ticks != RS * FPS) begin bad++; $display("FAIL seq_ticks got=%0d required=%0d", ticks, RS * FPS); end
    total++;
    if (phase !== 2'd3 || game_over !== 1'b1) begin
      bad++; $display("FAIL seq_over phase=%0d game_over=%b required=3/1", phase, game_over);
    end
  endtask

  task automatic test_abort();
    start = 0; cycle();
    start = 1; cycle();
    total++;
    if (phase !== 2'd0 || game_over !== 1'b0) begin bad++; $display("FAIL over_to_idle phase=%0d required=0", phase); end
    repeat (3) cycle();
    total++;
    if (phase !== 2'd0) begin bad++; $display("FAIL held_start phase=%0d required=0", phase); end
    start = 0; cycle(); start = 1; cycle();
    total++;
    if (phase !== 2'd1 || countdown !== 4'd3) begin
      bad++; $display("FAIL restart phase=%0d countdown=%0d required=1/3", phase, countdown);
    end
    repeat (FPS) begin ThisFrameEnd = 1; cycle(); ThisFrameEnd = 0; cycle(); end
    total++;
    if (countdown !== 4'd2) begin bad++; $display("FAIL abort_pre countdown=%0d required=2", countdown); end
    enter_game = 0; cycle();
    total++;
    if (phase !== 2'd0 || countdown !== 4'd0) begin
      bad++; $display("FAIL abort phase=%0d countdown=%0d required=0/0", phase, countdown);
    end
    enter_game = 1; start = 0; cycle();
  endtask

  task automatic test_reset_midgame();
    start = 1; cycle();
    set_box0(120, 220, 10, 90);
    for (int n = 1; n <= CDS * FPS + 1; n++) begin
      predict_valid = (n == 1); ThisFrameEnd = 1; cycle();
      predict_valid = 0; ThisFrameEnd = 0;
      if (n <= CDS * FPS) cycle();
    end
    total++;
    if (phase !== 2'd2 || frame_tick !== 1'b1 || box_valid !== 2'b01 || left[0] !== 11'd120) begin
      bad++; $display("FAIL midgame_pre phase=%0d tick=%b valid=%b left=%0d required=2/1/01/120",
        phase, frame_tick, box_valid, left[0]);
    end
    i_rst_n = 0;
    #1;
    total++;
    if ({left, right, up, down, box_valid, phase, countdown, time_left, frame_tick, game_over} !== '0) begin
      bad++; $display("FAIL midgame_reset got=%h required=0",
        {left, right, up, down, box_valid, phase, countdown, time_left, frame_tick, game_over});
    end
    model_reset();
    start = 0;
    @(posedge i_clk);
    #1 i_rst_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      enter_game    = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) start = ~start;
      predict_valid = ($urandom_range(0, 3) == 0);
      ThisFrameEnd  = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < 2; p++) begin
        left_in[p]  = CW'($urandom_range(0, 2047)); right_in[p] = CW'($urandom_range(0, 2047));
        up_in[p]    = CW'($urandom_range(0, 2047)); down_in[p]  = CW'($urandom_range(0, 2047));
      end
      cycle();
      total++;
      if (phase !== 2'(m_phase()) || countdown !== 4'(m_countdown()) || time_left !== 7'(m_time_left())) begin
        bad++; $display("FAIL rand_game cyc=%0d got=%0d/%0d/%0d required=%0d/%0d/%0d",
          c, phase, countdown, time_left, m_phase(), m_countdown(), m_time_left());
      end
      total++;
      if (frame_tick !== m_tick || game_over !== (m_phase() == 3)) begin
        bad++; $display("FAIL rand_tick cyc=%0d tick=%b over=%b required=%b/%b",
          c, frame_tick, game_over, m_tick, m_phase() == 3);
      end
      total++;
      if (left !== m_l || right !== m_r || up !== m_u || down !== m_d || box_valid !== m_bv) begin
        bad++; $display("FAIL rand_box cyc=%0d got=%h/%h/%h/%h/%b required=%h/%h/%h/%h/%b",
          c, left, right, up, down, box_valid, m_l, m_r, m_u, m_d, m_bv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_commit();
    test_simultaneous_stale();
    test_full_sequence();
    test_abort();
    test_reset_midgame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
